// File: rtl/mblk_raster_addr_gen.sv
// Macroblock-scan to raster write-address generator.
// Streams pixels through one output register and tags each with its frame-buffer address.
module mblk_raster_addr_gen #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 22,
   parameter int DIM_W  = 12
) (
   input  logic              iClk,
   input  logic              iRstN,
   input  logic              iStart,
   input  logic [1:0]        iMbType,
   input  logic [DIM_W-1:0]  iFrameW,
   input  logic [DIM_W-1:0]  iFrameH,
   input  logic [ADDR_W-1:0] iBaseAddr,
   input  logic              iValid,
   output logic              oReady,
   input  logic [DATA_W-1:0] iData,
   output logic              oValid,
   input  logic              iReady,
   output logic [DATA_W-1:0] oData,
   output logic [ADDR_W-1:0] oAddr,
   output logic              oBlkLast,
   output logic              oLast,
   output logic              oBusy,
   output logic              oErr
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t state_q, state_d;
   logic [5:0] bm1_q, bm1_d;
   logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
   logic [5:0] px_q, px_d, py_q, py_d;
   logic [DIM_W-1:0] bx_q, bx_d, by_q, by_d;
   // row_q: address of column 0 of the current pixel row;
   // brow_q: same for the top row of the current block row
   logic [ADDR_W-1:0] row_q, row_d, brow_q, brow_d;
   logic ovalid_q, ovalid_d;
   logic [DATA_W-1:0] odata_q, odata_d;
   logic [ADDR_W-1:0] oaddr_q, oaddr_d;
   logic oblk_q, oblk_d, olast_q, olast_d;
   logic err_q, err_d;

   logic [DIM_W-1:0] b_cfg, b_m1, blk_w;
   logic [ADDR_W-1:0] w_ext, addr, row_nxt;
   logic cfg_ok, ready, accept;
   logic row_end, blk_end, brow_end, frm_end;

   always_comb begin
      b_cfg = '0;
      unique case (iMbType)
         2'b01:   b_cfg = DIM_W'(64);
         2'b10:   b_cfg = DIM_W'(32);
         2'b11:   b_cfg = DIM_W'(16);
         default: b_cfg = '0;
      endcase
   end

   assign b_m1   = b_cfg - DIM_W'(1);
   assign cfg_ok = (b_cfg != '0) &&
                   (iFrameW >= b_cfg) && (iFrameH >= b_cfg) &&
                   ((iFrameW & b_m1) == '0) &&
                   ((iFrameH & b_m1) == '0);

   assign blk_w    = DIM_W'(bm1_q) + DIM_W'(1);
   assign w_ext    = ADDR_W'(w_q);
   assign row_nxt  = row_q + w_ext;
   assign addr     = row_q + ADDR_W'(bx_q) + ADDR_W'(px_q);
   assign row_end  = (px_q == bm1_q);
   assign blk_end  = row_end && (py_q == bm1_q);
   assign brow_end = blk_end && ((bx_q + blk_w) == w_q);
   assign frm_end  = brow_end && ((by_q + blk_w) == h_q);

   assign ready  = (state_q == RUN) && (!ovalid_q || iReady);
   assign accept = iValid && ready;

   always_comb begin
      state_d  = state_q;
      bm1_d    = bm1_q;
      w_d      = w_q;
      h_d      = h_q;
      px_d     = px_q;
      py_d     = py_q;
      bx_d     = bx_q;
      by_d     = by_q;
      row_d    = row_q;
      brow_d   = brow_q;
      ovalid_d = ovalid_q;
      odata_d  = odata_q;
      oaddr_d  = oaddr_q;
      oblk_d   = oblk_q;
      olast_d  = olast_q;
      err_d    = 1'b0;

      if (ovalid_q && iReady) ovalid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (iStart) begin
               if (cfg_ok) begin
                  state_d = RUN;
                  bm1_d   = b_m1[5:0];
                  w_d     = iFrameW;
                  h_d     = iFrameH;
                  px_d    = '0;
                  py_d    = '0;
                  bx_d    = '0;
                  by_d    = '0;
                  row_d   = iBaseAddr;
                  brow_d  = iBaseAddr;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (accept) begin
               ovalid_d = 1'b1;
               odata_d  = iData;
               oaddr_d  = addr;
               oblk_d   = blk_end;
               olast_d  = frm_end;
               if (!row_end) begin
                  px_d = px_q + 6'd1;
               end else begin
                  px_d = '0;
                  if (!blk_end) begin
                     py_d  = py_q + 6'd1;
                     row_d = row_nxt;
                  end else if (!brow_end) begin
                     py_d  = '0;
                     bx_d  = bx_q + blk_w;
                     row_d = brow_q;
                  end else begin
                     py_d   = '0;
                     bx_d   = '0;
                     by_d   = by_q + blk_w;
                     row_d  = row_nxt;
                     brow_d = row_nxt;
                     if (frm_end) state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q  <= IDLE;
         bm1_q    <= '0;
         w_q      <= '0;
         h_q      <= '0;
         px_q     <= '0;
         py_q     <= '0;
         bx_q     <= '0;
         by_q     <= '0;
         row_q    <= '0;
         brow_q   <= '0;
         ovalid_q <= 1'b0;
         odata_q  <= '0;
         oaddr_q  <= '0;
         oblk_q   <= 1'b0;
         olast_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bm1_q    <= bm1_d;
         w_q      <= w_d;
         h_q      <= h_d;
         px_q     <= px_d;
         py_q     <= py_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         row_q    <= row_d;
         brow_q   <= brow_d;
         ovalid_q <= ovalid_d;
         odata_q  <= odata_d;
         oaddr_q  <= oaddr_d;
         oblk_q   <= oblk_d;
         olast_q  <= olast_d;
         err_q    <= err_d;
      end
   end

   assign oReady   = ready;
   assign oValid   = ovalid_q;
   assign oData    = odata_q;
   assign oAddr    = oaddr_q;
   assign oBlkLast = oblk_q;
   assign oLast    = olast_q;
   assign oBusy    = (state_q == RUN) || ovalid_q;
   assign oErr     = err_q;

endmodule

// File: tb/tb_mblk_raster_addr_gen.sv
// Randomized bench for mblk_raster_addr_gen against an arithmetic
// pixel-index-to-address model, plus literal address pins.
module tb_mblk_raster_addr_gen;

   localparam int AW = 22;

   logic iClk = 1'b0;
   logic iRstN = 1'b0;
   logic iStart = 1'b0;
   logic [1:0] iMbType = '0;
   logic [11:0] iFrameW = '0, iFrameH = '0;
   logic [AW-1:0] iBaseAddr = '0;
   logic iValid = 1'b0;
   logic oReady;
   logic [7:0] iData = '0;
   logic oValid;
   logic iReady = 1'b0;
   logic [7:0] oData;
   logic [AW-1:0] oAddr;
   logic oBlkLast, oLast, oBusy, oErr;

   mblk_raster_addr_gen #(.DATA_W(8), .ADDR_W(AW), .DIM_W(12)) dut (
      .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iMbType(iMbType),
      .iFrameW(iFrameW), .iFrameH(iFrameH), .iBaseAddr(iBaseAddr),
      .iValid(iValid), .oReady(oReady), .iData(iData),
      .oValid(oValid), .iReady(iReady), .oData(oData), .oAddr(oAddr),
      .oBlkLast(oBlkLast), .oLast(oLast), .oBusy(oBusy), .oErr(oErr)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [7:0] d;
      logic [AW-1:0] a;
      logic bl;
      logic lst;
   } beat_t;

   int total = 0, bad = 0;
   beat_t q[$];
   beat_t prev;
   bit mon_en = 0, active = 0, err_exp = 0, held = 0;
   int N = 0, acc = 0, rcv = 0;
   int m_b = 16, m_w = 16, m_h = 16;
   logic [AW-1:0] m_base = '0;
   logic [AW-1:0] got_addr [0:8191];
   bit got_bl [0:8191];
   bit got_last [0:8191];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Pixel k of the macroblock stream -> raster position, by plain arithmetic
   function automatic beat_t model(input int k, input logic [7:0] d);
      beat_t r;
      int bpr, blk, off, px, py, bx, by;
      longint a;
      bpr = m_w / m_b;
      blk = k / (m_b * m_b);
      off = k % (m_b * m_b);
      py = off / m_b;
      px = off % m_b;
      bx = (blk % bpr) * m_b;
      by = (blk / bpr) * m_b;
      a = longint'(m_base) + longint'(by + py) * m_w + bx + px;
      r.d = d;
      r.a = a[AW-1:0];
      r.bl = (off == m_b * m_b - 1);
      r.lst = (k == N - 1);
      return r;
   endfunction

   always @(negedge iClk) begin
      bit run;
      if (mon_en) begin
         run = active && (acc < N);
         chk("busy", oBusy, run || oValid);
         chk("ready", oReady, run && (!oValid || iReady));
         chk("err", oErr, err_exp);
         if (held) begin
            chk("hold_valid", oValid, 1);
            chk("hold_data", oData, prev.d);
            chk("hold_addr", oAddr, prev.a);
            chk("hold_flags", {oBlkLast, oLast}, {prev.bl, prev.lst});
         end
         if (oValid) begin
            chk("beat_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
               chk("data", oData, q[0].d);
               chk("addr", oAddr, q[0].a);
               chk("blklast", oBlkLast, q[0].bl);
               chk("last", oLast, q[0].lst);
               if (iReady) begin
                  if (rcv < 8192) begin
                     got_addr[rcv] = oAddr;
                     got_bl[rcv] = oBlkLast;
                     got_last[rcv] = oLast;
                  end
                  void'(q.pop_front());
                  rcv++;
               end
            end
         end
         held = oValid && !iReady;
         prev = '{oData, oAddr, oBlkLast, oLast};
         if (iValid && oReady && run) begin
            q.push_back(model(acc, iData));
            acc++;
         end
      end else begin
         held = 0;
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, oReady, 0);
      chk({tag, "_valid"}, oValid, 0);
      chk({tag, "_blklast"}, oBlkLast, 0);
      chk({tag, "_last"}, oLast, 0);
      chk({tag, "_busy"}, oBusy, 0);
      chk({tag, "_err"}, oErr, 0);
      chk({tag, "_data"}, oData, 0);
      chk({tag, "_addr"}, oAddr, 0);
   endtask

   task automatic run_frame(input logic [1:0] t, input int w, input int h,
                            input logic [AW-1:0] base, input int pv,
                            input int pr, input int abort_at);
      m_b = (t == 2'b01) ? 64 : (t == 2'b10) ? 32 : 16;
      m_w = w;
      m_h = h;
      m_base = base;
      N = w * h;
      acc = 0;
      rcv = 0;
      q.delete();
      iMbType = t;
      iFrameW = 12'(w);
      iFrameH = 12'(h);
      iBaseAddr = base;
      iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      active = 1;
      for (int c = 0; c < N * 20 + 200; c++) begin
         if (rcv == N) break;
         if (abort_at > 0 && acc >= abort_at) break;
         iValid = ($urandom_range(99) < pv);
         iData = 8'($urandom);
         iReady = ($urandom_range(99) < pr);
         // starts and config noise while running must be ignored
         iStart = (acc < N) && ($urandom_range(99) < 3);
         iMbType = 2'($urandom);
         iFrameW = 12'($urandom);
         iFrameH = 12'($urandom);
         iBaseAddr = AW'($urandom);
         @(posedge iClk); #1;
      end
      iStart = 1'b0;
      iValid = 1'b0;
      if (abort_at == 0) begin
         chk("frame_done", rcv, N);
         iReady = 1'b1;
         repeat (3) begin
            @(posedge iClk); #1;
         end
         chk("queue_drained", q.size(), 0);
         active = 0;
      end
   endtask

   task automatic bad_start(input logic [1:0] t, input int w, input int h);
      iMbType = t;
      iFrameW = 12'(w);
      iFrameH = 12'(h);
      iBaseAddr = 22'h00_0100;
      iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      err_exp = 1;
      chk("err_pulse", oErr, 1);
      chk("err_not_ready", oReady, 0);
      @(posedge iClk); #1;
      err_exp = 0;
      chk("err_one_cycle", oErr, 0);
      chk("err_idle_busy", oBusy, 0);
   endtask

   int cnt [0:1023];
   int ndist;
   beat_t mb;

   initial begin
      #1;
      check_zero("reset_async");
      repeat (2) begin
         @(posedge iClk); #1;
      end
      check_zero("reset");
      iRstN = 1'b1;
      iReady = 1'b1;
      @(posedge iClk); #1;
      mon_en = 1;

      // 16x16 blocks, 32x32 frame, base 0, no backpressure
      run_frame(2'b11, 32, 32, '0, 100, 100, 0);
      chk("a_px0", got_addr[0], 0);
      chk("a_px15", got_addr[15], 15);
      chk("a_px16", got_addr[16], 32);
      chk("a_px255", got_addr[255], 495);
      chk("a_px255_bl", got_bl[255], 1);
      chk("a_px256", got_addr[256], 16);
      chk("a_px1023", got_addr[1023], 1023);
      chk("a_px1023_last", got_last[1023], 1);
      chk("a_px1023_bl", got_bl[1023], 1);
      chk("a_px1022_last", got_last[1022], 0);
      for (int i = 0; i < 1024; i++) cnt[i] = 0;
      for (int i = 0; i < 1024; i++)
         if (got_addr[i] < 1024) cnt[got_addr[i]]++;
      ndist = 0;
      for (int i = 0; i < 1024; i++) if (cnt[i] == 1) ndist++;
      chk("a_unique", ndist, 1024);
      mb = model(255, 8'h00);
      chk("model_pin_255", mb.a, 495);
      mb = model(256, 8'h00);
      chk("model_pin_256", mb.a, 16);

      // 64x64 blocks, 128x64 frame, base 0x1000
      run_frame(2'b01, 128, 64, 22'h1000, 100, 100, 0);
      chk("b_px4096", got_addr[4096], 22'h1040);
      chk("b_px8191", got_addr[8191], 22'h2FFF);
      chk("b_px8191_last", got_last[8191], 1);

      // 32x32 blocks with random backpressure on both sides
      run_frame(2'b10, 32, 32, AW'($urandom), 50, 50, 0);
      run_frame(2'b10, 64, 96, AW'($urandom), 50, 50, 0);

      bad_start(2'b00, 64, 64);
      bad_start(2'b11, 40, 32);
      bad_start(2'b01, 128, 32);

      // base wrap
      run_frame(2'b11, 16, 16, 22'h3FFFF0, 100, 100, 0);
      chk("w_px0", got_addr[0], 22'h3FFFF0);
      chk("w_px16", got_addr[16], 22'h000000);
      chk("w_px255", got_addr[255], 22'h0000EF);
      chk("w_px255_last", got_last[255], 1);

      // reset mid-frame
      run_frame(2'b11, 32, 32, 22'h2000, 70, 80, 100);
      mon_en = 0;
      iRstN = 1'b0;
      #1;
      check_zero("midrst_async");
      @(posedge iClk); #1;
      check_zero("midrst");
      iRstN = 1'b1;
      active = 0;
      q.delete();
      @(posedge iClk); #1;
      check_zero("postrst");
      mon_en = 1;
      run_frame(2'b11, 32, 32, 22'h2000, 70, 80, 0);
      chk("restart_first", got_addr[0], 22'h2000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mblk_raster_addr_gen.md
# mblk_raster_addr_gen

Macroblock-to-raster write-address generator. Accepts a pixel stream in macroblock scan order: blocks left-to-right, top-to-bottom; pixels row-major inside each block. For each pixel it emits the linear raster frame-buffer address, so a memory writer can rebuild the raster image. It is the write-side counterpart of the raster-to-macroblock read path and uses the `teMacroBlockType` encoding from `tPImageProcessing`.

## Interface
- `DATA_W`, 8: pixel width in bits.
- `ADDR_W`, 22: frame-buffer address width in bits.
- `DIM_W`, 12: width of the frame-dimension inputs.
- `iClk`  in  1  clock; all logic is on the rising edge.
- `iRstN`  in  1  asynchronous, active-low reset.
- `iStart`  in  1  single-cycle pulse; latches the configuration inputs. Honoured only in IDLE.
- `iMbType`  in  2  `teMacroBlockType`: 01 = 64x64, 10 = 32x32, 11 = 16x16. 00 is invalid.
- `iFrameW`  in  DIM_W  frame width in pixels.
- `iFrameH`  in  DIM_W  frame height in pixels.
- `iBaseAddr`  in  ADDR_W  address of pixel (0,0).
- `iValid`  in  1  input pixel valid.
- `oReady`  out  1  block can accept an input pixel.
- `iData`  in  DATA_W  input pixel.
- `oValid`  out  1  output pixel and address valid.
- `iReady`  in  1  downstream accepts the output.
- `oData`  out  DATA_W  registered pixel.
- `oAddr`  out  ADDR_W  raster address of `oData`.
- `oBlkLast`  out  1  `oData` is the last pixel of a macroblock.
- `oLast`  out  1  `oData` is the last pixel of the frame.
- `oBusy`  out  1  high while the state is RUN or `oValid` is high.
- `oErr`  out  1  one-cycle pulse when a start carries an invalid configuration.

## Operation
- **States:** IDLE and RUN.
- **Block size B** is derived from the latched `iMbType`: 64, 32 or 16.
- **Start in IDLE:** `iStart` latches type, W, H and base.
  - Valid configuration: type ≠ 00, W ≥ B, H ≥ B, W mod B = 0, H mod B = 0. A valid start clears all counters and moves to RUN.
  - Any other configuration: `oErr` pulses for 1 cycle and the state stays IDLE.
- `iStart` in RUN is ignored.
- **Counters:** px and py (0..B-1), plus block origins bx and by (multiples of B).
- **Advance on each accepted input** (`iValid && oReady`):
  - px increments.
  - When px = B-1: px wraps to 0 and py increments.
  - When py = B-1 and px = B-1 (end of block): py wraps to 0 and bx += B.
  - When bx + B = W at end of block: bx wraps to 0 and by += B.
  - When by + B = H at that point (end of frame): go to IDLE.
- **Address:** `oAddr` = (base + (by+py)·W + bx + px) mod 2^ADDR_W. The result must be computed incrementally (row-start accumulators); no combinational multiplier in the issue path.
- `oBlkLast` is high when px = py = B-1. `oLast` is high on the frame's final pixel; `oBlkLast` is also high on that pixel.
- `oReady` = (state = RUN) && (!`oValid` || `iReady`). It is 0 in IDLE.
- `oData` passes `iData` through unchanged.

## Timing
- **Reset:** state IDLE; `oReady`, `oValid`, `oBlkLast`, `oLast`, `oBusy` and `oErr` are 0; `oData` and `oAddr` are 0; all counters are 0.
- **Latency:**
  - `iStart` with a valid configuration → `oReady` high on the next cycle (when `oValid` = 0).
  - Input accepted in cycle n → `oValid` and its address are present in cycle n+1.
- **Output handshake:** `oValid`, `oData`, `oAddr`, `oBlkLast` and `oLast` hold stable while `oValid && !iReady`.
  - A new beat may be loaded in the same cycle the current one is consumed, giving full throughput of 1 pixel/cycle.
- **After the last pixel is accepted:** the state is IDLE on the next cycle. `oBusy` stays high until the `oLast` beat is consumed.
- A new `iStart` is accepted in any IDLE cycle, including while the `oLast` beat is still pending. The pending beat is delivered unchanged.
- **Reset mid-frame:** all outputs return to reset values immediately. The pending output beat is dropped and no partial state survives.
- `iValid` while `oReady` = 0 has no effect.
- Address overflow wraps modulo 2^ADDR_W with no error.

## Test plan
- **16x16 blocks, 32x32 frame, base 0, `iReady` = 1.**
  - Pixel 0 → addr 0; pixel 15 → 15; pixel 16 → 32.
  - Pixel 255 → 495 with `oBlkLast`; pixel 256 → 16.
  - Pixel 1023 → 1023 with `oLast` and `oBlkLast`.
  - Every address 0..1023 appears exactly once.
- **64x64 blocks, 128x64 frame, base 0x1000.**
  - Pixel 4096 → 0x1040.
  - Final pixel 8191 → 0x1000 + 63·128 + 127 = 0x2FFF with `oLast`.
- **Backpressure, 32x32 blocks, 32x32 frame.** Random `iValid`/`iReady` at 50%.
  - Outputs stay stable while stalled.
  - Addresses match a reference model in order.
  - No beat is lost or duplicated.
  - `oBusy` falls only after the `oLast` handshake.
- **Invalid starts:** type 00; type 16x16 with W = 40; type 64x64 with H = 32.
  - Each gives a 1-cycle `oErr`; the state stays IDLE and `oReady` stays 0.
  - A following valid start proceeds normally.
- **Reset mid-frame.** Assert `iRstN` = 0 after 100 pixels.
  - All outputs read 0 during reset.
  - A restart yields first address = base.
- **Base wrap, ADDR_W = 22.** Base 0x3FFFF0, 16x16 blocks, 16x16 frame.
  - Pixel 16 → addr 0x000000 (wrapped); pixel 255 → 0x0000EF.
